mem_stage_bus: RTL and testbench
================================

Name: mem_stage_bus

Overview:
- Parametrised successor to the combinational MEM stage.
- Performs loads and stores over a req/ack data bus with a variable number of wait states, and stalls the pipeline while a transfer is in flight.
- Handles byte-lane steering, sign/zero extension, alignment exceptions and bus timeout.
- Sits between the EX/MEM and MEM/WB registers; drives the stall controller through stallreq_o.

Parameters:
- ADDR_W, 32, bus address width; mem_addr_i is truncated to ADDR_W bits.
- TIMEOUT_CYC, 255, maximum BUSY cycles without ack before a bus error (1..65535).
- BIG_ENDIAN, 1, byte-lane order: 1 = address offset 0 is lane 3 (sel 4'b1000); 0 = address offset 0 is lane 0.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- wd_i  in  5  destination register
- wreg_i  in  1  write-enable from EX
- wdata_i  in  32  ALU result
- mem_op_i  in  4  0 NONE, 1 LB, 2 LBU, 3 LH, 4 LHU, 5 LW, 6 SB, 7 SH, 8 SW, 9 LL, 10 SC; other codes = NONE
- mem_addr_i  in  32  effective address
- reg2_i  in  32  store data
- llbit_clr_i  in  1  clear link bit (exception/ERET)
- wd_o  out  5  destination register to MEM/WB
- wreg_o  out  1  write-enable to MEM/WB
- wdata_o  out  32  result to MEM/WB
- stallreq_o  out  1  pipeline stall request
- adel_o  out  1  load/LL address misaligned
- ades_o  out  1  store/SC address misaligned
- bus_err_o  out  1  one-cycle pulse on bus timeout
- bus_req_o  out  1  bus request, registered
- bus_we_o  out  1  bus write
- bus_addr_o  out  ADDR_W  word-aligned address (low 2 bits 0)
- bus_sel_o  out  4  byte-lane enables
- bus_wdata_o  out  32  store data replicated to lanes
- bus_ack_i  in  1  transfer complete; valid only while bus_req_o=1
- bus_rdata_i  in  32  read data, sampled with ack

Behaviour:
- Reset:
  - state IDLE.
  - bus_req_o, bus_we_o, bus_addr_o, bus_sel_o, bus_wdata_o, timeout counter, result register and llbit all 0.
  - While rst=1 every combinational output is forced to 0.
  - Reset mid-transfer aborts: bus_req_o=0 after the edge; no writeback.
- Alignment:
  - H ops require addr[0]=0; W/LL/SC require addr[1:0]=0.
  - Misaligned op: adel_o/ades_o=1 combinationally in IDLE, wreg_o=0, no bus cycle, no stall.
- IDLE:
  - NONE op: passthrough, wd_o=wd_i, wreg_o=wreg_i, wdata_o=wdata_i, stallreq_o=0.
  - Aligned memory op: stallreq_o=1. At the next edge, latch addr/sel/wdata/we, set bus_req_o=1, go BUSY.
- BUSY:
  - stallreq_o=1.
  - Counter increments each cycle.
  - On bus_ack_i: latch the extended read result, bus_req_o=0 at that edge, go DONE.
  - Counter reaching TIMEOUT_CYC without ack: bus_req_o=0, bus_err_o pulses 1 for one cycle, go DONE with writeback suppressed.
- DONE:
  - stallreq_o=0; pipeline advances at this edge.
  - wd_o=wd_i; wreg_o=wreg_i & load & !err; wdata_o=result register.
  - Stores: wreg_o=0, except SC (see optional feature).
  - Next state IDLE. A back-to-back memory op is detected in the following IDLE cycle.
- Latency: minimum stall is 2 cycles (ack in first BUSY cycle); N extra ack wait cycles add N.
- Lane steering:
  - SB replicates reg2_i[7:0] to all lanes, sel one-hot on addr[1:0].
  - SH replicates [15:0], sel 2'b11 pair.
  - SW sel 4'hF.
  - LB/LH sign-extend the selected lane(s); LBU/LHU zero-extend.
- An ack while bus_req_o=0 is ignored.

Optional Feature:
- MEM_LLSC_EN defined:
  - LL acts as LW and sets llbit at the DONE edge.
  - SC with llbit=1 performs the store and writes 1 to rd; clears llbit.
  - SC with llbit=0: no bus cycle, no stall, writes 0.
  - llbit_clr_i clears llbit; it has priority over an LL set in the same cycle.
- MEM_LLSC_EN undefined:
  - LL behaves as LW; SC behaves as SW and writes 1.
  - llbit_clr_i is ignored; no llbit register.

Test Plan:
- LB addr 0x1003, BIG_ENDIAN=1, rdata 0x112233F4, ack on first BUSY cycle -> bus_sel_o=0001, stallreq_o high 2 cycles, wdata_o=0xFFFFFFF4.
- SH addr 0x2002, reg2_i 0xAAAABEEF, ack after 3 wait cycles -> bus_we_o=1, bus_sel_o=0011, bus_wdata_o=0xBEEFBEEF, stall 5 cycles, wreg_o=0.
- LW addr 0x3001 -> adel_o=1, bus_req_o stays 0, stallreq_o=0; SW addr 0x3002 -> ades_o=1.
- LW with no ack, TIMEOUT_CYC=4 -> bus_req_o drops after 4 BUSY cycles, bus_err_o single pulse, wreg_o=0.
- rst asserted in 2nd BUSY cycle -> next cycle bus_req_o=0, state IDLE; next LW completes normally.
- MEM_LLSC_EN: LL 0x40, then SC 0x40 -> store issued, wdata_o=1; llbit_clr_i pulse then SC -> no bus cycle, wdata_o=0.

Source files
------------

// File: rtl/mem_stage_bus.sv
`default_nettype none
// ============================================================================
// Module   : mem_stage_bus
// Purpose  : MEM pipeline stage doing loads/stores over a req/ack bus with
//            wait states, lane steering, alignment traps and bus timeout.
//            Optional LL/SC link bit enabled by defining MEM_LLSC_EN.
// Revision : 1.0 - initial release
// ============================================================================
module mem_stage_bus #(
    parameter int ADDR_W      = 32,
    parameter int TIMEOUT_CYC = 255,
    parameter bit BIG_ENDIAN  = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [4:0]        wd_i,
    input  logic              wreg_i,
    input  logic [31:0]       wdata_i,
    input  logic [3:0]        mem_op_i,
    input  logic [31:0]       mem_addr_i,
    input  logic [31:0]       reg2_i,
    input  logic              llbit_clr_i,
    output logic [4:0]        wd_o,
    output logic              wreg_o,
    output logic [31:0]       wdata_o,
    output logic              stallreq_o,
    output logic              adel_o,
    output logic              ades_o,
    output logic              bus_err_o,
    output logic              bus_req_o,
    output logic              bus_we_o,
    output logic [ADDR_W-1:0] bus_addr_o,
    output logic [3:0]        bus_sel_o,
    output logic [31:0]       bus_wdata_o,
    input  logic              bus_ack_i,
    input  logic [31:0]       bus_rdata_i
);

    localparam logic [3:0]  c_op_lb   = 4'd1;
    localparam logic [3:0]  c_op_lbu  = 4'd2;
    localparam logic [3:0]  c_op_lh   = 4'd3;
    localparam logic [3:0]  c_op_lhu  = 4'd4;
    localparam logic [3:0]  c_op_lw   = 4'd5;
    localparam logic [3:0]  c_op_sb   = 4'd6;
    localparam logic [3:0]  c_op_sh   = 4'd7;
    localparam logic [3:0]  c_op_sw   = 4'd8;
    localparam logic [3:0]  c_op_ll   = 4'd9;
    localparam logic [3:0]  c_op_sc   = 4'd10;

    localparam logic [1:0]  c_st_idle = 2'd0;
    localparam logic [1:0]  c_st_busy = 2'd1;
    localparam logic [1:0]  c_st_done = 2'd2;

    localparam logic [15:0] c_tmo_last = 16'(TIMEOUT_CYC - 1);

    logic [1:0]        r_state;
    logic [15:0]       r_cnt;
    logic [3:0]        r_op;
    logic [1:0]        r_lane;
    logic              r_wb;
    logic              r_err;
    logic [31:0]       r_result;
    logic              r_req;
    logic              r_we;
    logic [ADDR_W-1:0] r_addr;
    logic [3:0]        r_sel;
    logic [31:0]       r_wdata;

    logic        w_sz_b, w_sz_h, w_sz_w, w_load, w_store;
    logic        w_mis, w_go, w_sc_fail, w_unused;
    logic [1:0]  w_lane;
    logic [3:0]  w_sel;
    logic [31:0] w_bwd, w_ext;
    logic [7:0]  w_byte_rd;
    logic [15:0] w_half_rd;

    always_comb begin
        w_sz_b  = 1'b0;
        w_sz_h  = 1'b0;
        w_sz_w  = 1'b0;
        w_load  = 1'b0;
        w_store = 1'b0;
        case (mem_op_i)
            c_op_lb, c_op_lbu: begin w_sz_b = 1'b1; w_load  = 1'b1; end
            c_op_lh, c_op_lhu: begin w_sz_h = 1'b1; w_load  = 1'b1; end
            c_op_lw, c_op_ll:  begin w_sz_w = 1'b1; w_load  = 1'b1; end
            c_op_sb:           begin w_sz_b = 1'b1; w_store = 1'b1; end
            c_op_sh:           begin w_sz_h = 1'b1; w_store = 1'b1; end
            c_op_sw, c_op_sc:  begin w_sz_w = 1'b1; w_store = 1'b1; end
            default: ;
        endcase
    end

    assign w_mis  = (w_sz_h & mem_addr_i[0]) | (w_sz_w & (|mem_addr_i[1:0]));
    assign w_go   = (w_load | w_store) & ~w_mis & ~w_sc_fail;
    // Bus lane holding the addressed byte; big-endian maps offset 0 to lane 3.
    assign w_lane = BIG_ENDIAN ? ~mem_addr_i[1:0] : mem_addr_i[1:0];
    assign w_sel  = w_sz_b ? (4'b0001 << w_lane) :
                    w_sz_h ? (w_lane[1] ? 4'b1100 : 4'b0011) : 4'hF;
    assign w_bwd  = !w_store ? 32'd0 :
                    w_sz_b   ? {4{reg2_i[7:0]}} :
                    w_sz_h   ? {2{reg2_i[15:0]}} : reg2_i;

    always_comb begin
        w_byte_rd = bus_rdata_i[7:0];
        case (r_lane)
            2'd1:    w_byte_rd = bus_rdata_i[15:8];
            2'd2:    w_byte_rd = bus_rdata_i[23:16];
            2'd3:    w_byte_rd = bus_rdata_i[31:24];
            default: ;
        endcase
        w_half_rd = r_lane[1] ? bus_rdata_i[31:16] : bus_rdata_i[15:0];
        case (r_op)
            c_op_lb:  w_ext = {{24{w_byte_rd[7]}}, w_byte_rd};
            c_op_lbu: w_ext = {24'd0, w_byte_rd};
            c_op_lh:  w_ext = {{16{w_half_rd[15]}}, w_half_rd};
            c_op_lhu: w_ext = {16'd0, w_half_rd};
            c_op_sc:  w_ext = 32'd1;
            default:  w_ext = bus_rdata_i;
        endcase
    end

    always_comb begin
        wd_o       = 5'd0;
        wreg_o     = 1'b0;
        wdata_o    = 32'd0;
        stallreq_o = 1'b0;
        adel_o     = 1'b0;
        ades_o     = 1'b0;
        if (!rst) begin
            wd_o = wd_i;
            case (r_state)
                c_st_idle: begin
                    if (w_mis) begin
                        adel_o = w_load;
                        ades_o = w_store;
                    end else if (w_go) begin
                        stallreq_o = 1'b1;
                    end else if (w_sc_fail) begin
                        wreg_o = wreg_i;
                    end else begin
                        wreg_o  = wreg_i;
                        wdata_o = wdata_i;
                    end
                end
                c_st_busy: stallreq_o = 1'b1;
                default: begin
                    wreg_o  = wreg_i & r_wb & ~r_err;
                    wdata_o = r_result;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= c_st_idle;
            r_cnt    <= 16'd0;
            r_op     <= 4'd0;
            r_lane   <= 2'd0;
            r_wb     <= 1'b0;
            r_err    <= 1'b0;
            r_result <= 32'd0;
            r_req    <= 1'b0;
            r_we     <= 1'b0;
            r_addr   <= '0;
            r_sel    <= 4'd0;
            r_wdata  <= 32'd0;
        end else begin
            r_err <= 1'b0;
            case (r_state)
                c_st_idle: begin
                    if (w_go) begin
                        r_req   <= 1'b1;
                        r_we    <= w_store;
                        r_addr  <= {mem_addr_i[ADDR_W-1:2], 2'b00};
                        r_sel   <= w_sel;
                        r_wdata <= w_bwd;
                        r_op    <= mem_op_i;
                        r_lane  <= w_lane;
                        r_wb    <= w_load | (mem_op_i == c_op_sc);
                        r_cnt   <= 16'd0;
                        r_state <= c_st_busy;
                    end
                end
                c_st_busy: begin
                    r_cnt <= r_cnt + 16'd1;
                    if (bus_ack_i && r_req) begin
                        r_result <= w_ext;
                        r_req    <= 1'b0;
                        r_state  <= c_st_done;
                    end else if (r_cnt == c_tmo_last) begin
                        r_req    <= 1'b0;
                        r_err    <= 1'b1;
                        r_state  <= c_st_done;
                    end
                end
                default: r_state <= c_st_idle;
            endcase
        end
    end

`ifdef MEM_LLSC_EN
    logic r_llbit;

    assign w_sc_fail = (mem_op_i == c_op_sc) & ~r_llbit;
    assign w_unused  = &{1'b0, mem_addr_i};

    // Clear request beats an LL completing in the same cycle.
    always_ff @(posedge clk) begin
        if (rst)
            r_llbit <= 1'b0;
        else if (llbit_clr_i)
            r_llbit <= 1'b0;
        else if (r_state == c_st_done && r_op == c_op_ll && !r_err)
            r_llbit <= 1'b1;
        else if (r_state == c_st_done && r_op == c_op_sc)
            r_llbit <= 1'b0;
    end
`else
    assign w_sc_fail = 1'b0;
    assign w_unused  = &{1'b0, llbit_clr_i, mem_addr_i};
`endif

    assign bus_err_o   = r_err;
    assign bus_req_o   = r_req;
    assign bus_we_o    = r_we;
    assign bus_addr_o  = r_addr;
    assign bus_sel_o   = r_sel;
    assign bus_wdata_o = r_wdata;

endmodule
`default_nettype wire

// File: tb/tb_mem_stage_bus.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : tb_mem_stage_bus
// Purpose  : Scoreboard bench for mem_stage_bus (BIG_ENDIAN=1, TIMEOUT_CYC=4).
// Revision : 1.0 - initial release
// ============================================================================
module tb_mem_stage_bus;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [4:0]  wd_i = 5'd0;
    logic        wreg_i = 1'b0;
    logic [31:0] wdata_i = 32'd0;
    logic [3:0]  mem_op_i = 4'd0;
    logic [31:0] mem_addr_i = 32'd0;
    logic [31:0] reg2_i = 32'd0;
    logic        llbit_clr_i = 1'b0;
    logic [4:0]  wd_o;
    logic        wreg_o;
    logic [31:0] wdata_o;
    logic        stallreq_o, adel_o, ades_o, bus_err_o;
    logic        bus_req_o, bus_we_o;
    logic [31:0] bus_addr_o;
    logic [3:0]  bus_sel_o;
    logic [31:0] bus_wdata_o;
    logic        bus_ack_i = 1'b0;
    logic [31:0] bus_rdata_i = 32'd0;

    always #5 clk = ~clk;

    mem_stage_bus #(.ADDR_W(32), .TIMEOUT_CYC(4), .BIG_ENDIAN(1'b1)) dut (
        .clk(clk), .rst(rst), .wd_i(wd_i), .wreg_i(wreg_i), .wdata_i(wdata_i),
        .mem_op_i(mem_op_i), .mem_addr_i(mem_addr_i), .reg2_i(reg2_i),
        .llbit_clr_i(llbit_clr_i), .wd_o(wd_o), .wreg_o(wreg_o), .wdata_o(wdata_o),
        .stallreq_o(stallreq_o), .adel_o(adel_o), .ades_o(ades_o),
        .bus_err_o(bus_err_o), .bus_req_o(bus_req_o), .bus_we_o(bus_we_o),
        .bus_addr_o(bus_addr_o), .bus_sel_o(bus_sel_o), .bus_wdata_o(bus_wdata_o),
        .bus_ack_i(bus_ack_i), .bus_rdata_i(bus_rdata_i)
    );

    typedef struct {
        logic [4:0]  wd;
        logic        wreg;
        logic [31:0] wdata;
        logic        adel, ades, err;
        int          stall;
        logic        bus;
        logic [3:0]  sel;
        logic        we;
        logic [31:0] bwd;
    } exp_t;

    exp_t q[$];
    int   total = 0;
    int   bad   = 0;
    logic op_valid = 1'b0;
    int   ack_wait = 0;
    bit   no_ack   = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    function automatic exp_t mk(input logic [4:0] wd, input logic wreg, input logic [31:0] wdata,
                                input logic adel, input logic ades, input logic err, input int stall,
                                input logic bus, input logic [3:0] sel, input logic we,
                                input logic [31:0] bwd);
        exp_t e;
        e.wd = wd; e.wreg = wreg; e.wdata = wdata; e.adel = adel; e.ades = ades;
        e.err = err; e.stall = stall; e.bus = bus; e.sel = sel; e.we = we; e.bwd = bwd;
        return e;
    endfunction

    // Bus slave: acks after ack_wait BUSY cycles unless no_ack is set.
    int busy_n = 0;
    always @(negedge clk) begin
        if (rst || !bus_req_o) begin
            busy_n    = 0;
            bus_ack_i = 1'b0;
        end else begin
            bus_ack_i = !no_ack && (busy_n == ack_wait);
            busy_n++;
        end
    end

    // Monitor: counts stall cycles, captures the bus cycle, checks on each advance.
    int          st_n = 0;
    bit          seen = 1'b0;
    logic [3:0]  sel_c = 4'd0;
    logic        we_c = 1'b0;
    logic [31:0] bwd_c = 32'd0;
    always @(negedge clk) begin
        exp_t e;
        if (rst) begin
            st_n = 0;
            seen = 1'b0;
        end else if (stallreq_o) begin
            st_n++;
            if (bus_req_o) begin
                seen  = 1'b1;
                sel_c = bus_sel_o;
                we_c  = bus_we_o;
                bwd_c = bus_wdata_o;
            end
        end else if (op_valid) begin
            if (q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_advance: got advance want none");
            end else begin
                e = q.pop_front();
                chk("wd", wd_o, e.wd);
                chk("wreg", wreg_o, e.wreg);
                if (e.wreg) chk("wdata", wdata_o, e.wdata);
                chk("adel", adel_o, e.adel);
                chk("ades", ades_o, e.ades);
                chk("bus_err", bus_err_o, e.err);
                chk("stall_cycles", st_n, e.stall);
                chk("bus_cycle", seen, e.bus);
                if (e.bus) begin
                    chk("bus_sel", sel_c, e.sel);
                    chk("bus_we", we_c, e.we);
                    if (e.we) chk("bus_wdata", bwd_c, e.bwd);
                end
            end
            st_n = 0;
            seen = 1'b0;
        end else begin
            st_n = 0;
            seen = 1'b0;
        end
    end

    task automatic issue(input logic [3:0] op, input logic [31:0] addr, input logic [31:0] r2,
                         input logic [31:0] wdat, input logic [31:0] rd, input int aw,
                         input bit na, input exp_t e);
        bit done = 1'b0;
        bus_rdata_i = rd;
        ack_wait    = aw;
        no_ack      = na;
        mem_op_i    = op;
        mem_addr_i  = addr;
        reg2_i      = r2;
        wd_i        = e.wd;
        wreg_i      = 1'b1;
        wdata_i     = wdat;
        q.push_back(e);
        op_valid    = 1'b1;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (!stallreq_o) begin
                done = 1'b1;
                break;
            end
        end
        if (!done) begin
            total++;
            bad++;
            $display("FAIL stall_bound op=%0d: got stalled want advance", op);
            q.delete();
        end
        @(posedge clk);
        #1;
        op_valid = 1'b0;
        mem_op_i = 4'd0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish want finish");
        $fatal(1);
    end

    initial begin
        // Reset with an aligned load presented: everything must read zero.
        wd_i = 5'd7; wreg_i = 1'b1; wdata_i = 32'h1234; mem_op_i = 4'd5; mem_addr_i = 32'h1000;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_stallreq", stallreq_o, 0);
        chk("rst_wreg", wreg_o, 0);
        chk("rst_wdata", wdata_o, 0);
        chk("rst_wd", wd_o, 0);
        chk("rst_bus_req", bus_req_o, 0);
        @(posedge clk); #1;
        rst = 1'b0; mem_op_i = 4'd0;
        @(negedge clk);
        chk("idle_bus_req", bus_req_o, 0);
        chk("idle_bus_sel", bus_sel_o, 0);
        chk("idle_bus_err", bus_err_o, 0);
        @(posedge clk); #1;

        issue(4'd0, 32'h0, 32'h0, 32'hDEADBEEF, 32'h0, 0, 0,
              mk(5'd3, 1, 32'hDEADBEEF, 0, 0, 0, 0, 0, 4'h0, 0, 32'h0));
        issue(4'd1, 32'h1003, 32'h0, 32'h0, 32'h112233F4, 0, 0,
              mk(5'd4, 1, 32'hFFFFFFF4, 0, 0, 0, 2, 1, 4'b0001, 0, 32'h0));
        issue(4'd2, 32'h1000, 32'h0, 32'h0, 32'h80FF0011, 1, 0,
              mk(5'd5, 1, 32'h00000080, 0, 0, 0, 3, 1, 4'b1000, 0, 32'h0));
        issue(4'd3, 32'h1002, 32'h0, 32'h0, 32'h12348765, 0, 0,
              mk(5'd6, 1, 32'hFFFF8765, 0, 0, 0, 2, 1, 4'b0011, 0, 32'h0));
        issue(4'd4, 32'h1000, 32'h0, 32'h0, 32'h9ABC0000, 0, 0,
              mk(5'd7, 1, 32'h00009ABC, 0, 0, 0, 2, 1, 4'b1100, 0, 32'h0));
        issue(4'd5, 32'h1004, 32'h0, 32'h0, 32'hCAFEF00D, 2, 0,
              mk(5'd8, 1, 32'hCAFEF00D, 0, 0, 0, 4, 1, 4'hF, 0, 32'h0));
        issue(4'd7, 32'h2002, 32'hAAAABEEF, 32'h0, 32'h0, 3, 0,
              mk(5'd9, 0, 32'h0, 0, 0, 0, 5, 1, 4'b0011, 1, 32'hBEEFBEEF));
        issue(4'd6, 32'h2001, 32'h123456A5, 32'h0, 32'h0, 0, 0,
              mk(5'd10, 0, 32'h0, 0, 0, 0, 2, 1, 4'b0100, 1, 32'hA5A5A5A5));
        issue(4'd8, 32'h2000, 32'h01020304, 32'h0, 32'h0, 0, 0,
              mk(5'd11, 0, 32'h0, 0, 0, 0, 2, 1, 4'hF, 1, 32'h01020304));
        // Misaligned accesses trap without a bus cycle.
        issue(4'd5, 32'h3001, 32'h0, 32'h0, 32'h0, 0, 0,
              mk(5'd12, 0, 32'h0, 1, 0, 0, 0, 0, 4'h0, 0, 32'h0));
        issue(4'd8, 32'h3002, 32'h0, 32'h0, 32'h0, 0, 0,
              mk(5'd13, 0, 32'h0, 0, 1, 0, 0, 0, 4'h0, 0, 32'h0));
        issue(4'd3, 32'h3001, 32'h0, 32'h0, 32'h0, 0, 0,
              mk(5'd14, 0, 32'h0, 1, 0, 0, 0, 0, 4'h0, 0, 32'h0));
        issue(4'd7, 32'h3003, 32'h0, 32'h0, 32'h0, 0, 0,
              mk(5'd15, 0, 32'h0, 0, 1, 0, 0, 0, 4'h0, 0, 32'h0));
        // Timeout after 4 BUSY cycles: error pulse and no writeback.
        issue(4'd5, 32'h4000, 32'h0, 32'h0, 32'h0, 0, 1,
              mk(5'd16, 0, 32'h0, 0, 0, 1, 5, 1, 4'hF, 0, 32'h0));
        @(negedge clk);
        chk("bus_err_pulse_end", bus_err_o, 0);
        @(posedge clk); #1;

        // Reset during the second BUSY cycle aborts the transfer.
        no_ack = 1'b1; mem_op_i = 4'd5; mem_addr_i = 32'h5000; wreg_i = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk("busy_before_rst", bus_req_o, 1);
        rst = 1'b1;
        @(posedge clk); #1;
        chk("abort_bus_req", bus_req_o, 0);
        rst = 1'b0; mem_op_i = 4'd0;
        @(negedge clk);
        chk("abort_idle_req", bus_req_o, 0);
        chk("abort_idle_stall", stallreq_o, 0);
        @(posedge clk); #1;
        issue(4'd5, 32'h5000, 32'h0, 32'h0, 32'h0BADF00D, 1, 0,
              mk(5'd17, 1, 32'h0BADF00D, 0, 0, 0, 3, 1, 4'hF, 0, 32'h0));

        // LL / SC sequence.
        issue(4'd9, 32'h40, 32'h0, 32'h0, 32'h00000077, 0, 0,
              mk(5'd18, 1, 32'h00000077, 0, 0, 0, 2, 1, 4'hF, 0, 32'h0));
        issue(4'd10, 32'h40, 32'h5, 32'h0, 32'h0, 0, 0,
              mk(5'd19, 1, 32'h1, 0, 0, 0, 2, 1, 4'hF, 1, 32'h5));
        issue(4'd9, 32'h40, 32'h0, 32'h0, 32'h00000088, 0, 0,
              mk(5'd20, 1, 32'h00000088, 0, 0, 0, 2, 1, 4'hF, 0, 32'h0));
        llbit_clr_i = 1'b1;
        @(posedge clk); #1;
        llbit_clr_i = 1'b0;
`ifdef MEM_LLSC_EN
        issue(4'd10, 32'h40, 32'h6, 32'h0, 32'h0, 0, 0,
              mk(5'd21, 1, 32'h0, 0, 0, 0, 0, 0, 4'h0, 0, 32'h0));
`else
        issue(4'd10, 32'h40, 32'h6, 32'h0, 32'h0, 0, 0,
              mk(5'd21, 1, 32'h1, 0, 0, 0, 2, 1, 4'hF, 1, 32'h6));
`endif

        repeat (3) @(posedge clk);
        chk("scoreboard_empty", q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
